// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - burst-locked round-robin arbiter for the shared VGA pixel-write port
// Optional forced revoke of a stuck owner: define ARB_TIMEOUT_EN.
module vga_write_arbiter #(
    parameter int N_REQ       = 3,
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9,
    parameter int TIMEOUT     = 4096
) (
    input  logic                           Clock,
    input  logic                           Resetn,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ-1:0]               done,
    input  logic [N_REQ*nX-1:0]            x_in,
    input  logic [N_REQ*nY-1:0]            y_in,
    input  logic [N_REQ*COLOR_DEPTH-1:0]   color_in,
    input  logic [N_REQ-1:0]               write_in,
    output logic [N_REQ-1:0]               grant,
    output logic [nX-1:0]                  VGA_x,
    output logic [nY-1:0]                  VGA_y,
    output logic [COLOR_DEPTH-1:0]         VGA_color,
    output logic                           VGA_write,
    output logic                           busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    winner;
    logic             win_valid;
    logic [IW-1:0]    next_ptr;
    logic [N_REQ-1:0] req_elig;
    logic [N_REQ-1:0] one_hot_base;
    logic             own_req;
    logic             own_done;
    logic             own_write;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]    own_cnt;
    logic [N_REQ-1:0] lockout;
    logic             expire;

    // A revoked requester stays excluded until it drops req at least once.
    assign req_elig = req & ~lockout;
    assign expire   = (own_cnt == CW'(TIMEOUT - 1));
`else
    assign req_elig = req;
`endif

    assign one_hot_base = {{(N_REQ-1){1'b0}}, 1'b1};
    assign own_req      = req[owner];
    assign own_done     = done[owner];
    assign own_write    = write_in[owner];
    assign next_ptr     = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // First eligible request at or after rr_ptr, wrapping at N_REQ.
    always_comb begin
        logic [IW:0] idx;
        winner    = '0;
        win_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(N_REQ)) begin
                idx = idx - (IW+1)'(N_REQ);
            end
            if (!win_valid && req_elig[idx[IW-1:0]]) begin
                win_valid = 1'b1;
                winner    = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            VGA_x     <= '0;
            VGA_y     <= '0;
            VGA_color <= '0;
            VGA_write <= 1'b0;
            busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            own_cnt   <= '0;
            lockout   <= '0;
`endif
        end else begin
            VGA_write <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            lockout   <= lockout & req;
`endif
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant <= one_hot_base << winner;
                        owner <= winner;
                        state <= OWN;
                        busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        own_cnt <= '0;
`endif
                    end
                end
                OWN: begin
`ifdef ARB_TIMEOUT_EN
                    own_cnt <= own_cnt + 1'b1;
                    if (expire) begin
                        grant   <= '0;
                        state   <= RELEASE;
                        rr_ptr  <= next_ptr;
                        lockout <= (lockout & req) | (one_hot_base << owner);
                    end else begin
`else
                    begin
`endif
                        // The exit cycle's pixel is still forwarded.
                        VGA_x     <= x_in[owner*nX +: nX];
                        VGA_y     <= y_in[owner*nY +: nY];
                        VGA_color <= color_in[owner*COLOR_DEPTH +: COLOR_DEPTH];
                        VGA_write <= own_write;
                        if (own_done || !own_req) begin
                            grant  <= '0;
                            state  <= RELEASE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb/tb_vga_write_arbiter.sv - scoreboard bench for vga_write_arbiter
module tb_vga_write_arbiter;

    localparam int N  = 3;
    localparam int NX = 10;
    localparam int NY = 9;
    localparam int CD = 9;

    logic            Clock = 1'b0;
    logic            Resetn;
    logic [N-1:0]    req, done, write_in, grant;
    logic [N*NX-1:0] x_in;
    logic [N*NY-1:0] y_in;
    logic [N*CD-1:0] color_in;
    logic [NX-1:0]   VGA_x;
    logic [NY-1:0]   VGA_y;
    logic [CD-1:0]   VGA_color;
    logic            VGA_write;
    logic            busy;

    int errors = 0;
    int checks = 0;
    logic [NX+NY+CD-1:0] exp_q[$];

    vga_write_arbiter #(
        .N_REQ(N), .nX(NX), .nY(NY), .COLOR_DEPTH(CD), .TIMEOUT(16)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .write_in(write_in),
        .grant(grant), .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color),
        .VGA_write(VGA_write), .busy(busy)
    );

    always #5 Clock = ~Clock;

    // Every write reaching the VGA port must match the next expected pixel.
    always @(negedge Clock) begin
        if (VGA_write === 1'b1) begin
            logic [NX+NY+CD-1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL vga_unexpected_write: got %h want no write", {VGA_x, VGA_y, VGA_color});
            end else begin
                e = exp_q.pop_front();
                if ({VGA_x, VGA_y, VGA_color} !== e) begin
                    errors++;
                    $display("FAIL vga_pixel: got %h want %h", {VGA_x, VGA_y, VGA_color}, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic put_pixel(input int r, input logic [NX-1:0] x, input logic [NY-1:0] y,
                             input logic [CD-1:0] c, input logic w);
        x_in[r*NX +: NX]     = x;
        y_in[r*NY +: NY]     = y;
        color_in[r*CD +: CD] = c;
        write_in[r]          = w;
    endtask

    task automatic apply_reset;
        Resetn = 1'b0; req = '0; done = '0; write_in = '0;
        x_in = '0; y_in = '0; color_in = '0;
        tick;
        Resetn = 1'b1;
        tick;
    endtask

    task automatic wait_grant(output int gap);
        gap = 0;
        while (grant === '0 && gap < 50) begin
            tick;
            gap++;
        end
        checks++;
        if (grant === '0) begin
            errors++;
            $display("FAIL grant_timeout: got grant=%b want nonzero within 50 cycles", grant);
        end
    endtask

    task automatic burst(input int own, input int n, input bit fin, input bit junk);
        logic [NX-1:0] x;
        logic [NY-1:0] y;
        logic [CD-1:0] c;
        logic [N-1:0]  oh;
        int            j;
        oh = 3'b001 << own;
        j  = (own + 1) % N;
        for (int p = 0; p < n; p++) begin
            x = NX'($urandom); y = NY'($urandom); c = CD'($urandom);
            put_pixel(own, x, y, c, 1'b1);
            exp_q.push_back({x, y, c});
            if (junk) put_pixel(j, ~x, ~y, ~c, 1'b1);
            done = (fin && p == n - 1) ? oh : '0;
            tick;
            if (p < n - 1) begin
                checks++;
                if (grant !== oh) begin
                    errors++;
                    $display("FAIL burst_grant_held: got %b want %b", grant, oh);
                end
            end
        end
        write_in = '0;
        done     = '0;
        if (fin) begin
            checks++;
            if (grant !== '0) begin
                errors++;
                $display("FAIL burst_release_grant: got %b want 000", grant);
            end
        end
    endtask

    task automatic test_reset;
        Resetn = 1'b0; req = '0; done = '0; write_in = '0;
        x_in = '1; y_in = '1; color_in = '1;
        tick;
        tick;
        checks++; if (grant !== '0)     begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
        checks++; if (VGA_write !== 0)  begin errors++; $display("FAIL reset_write: got %b want 0", VGA_write); end
        checks++; if (busy !== 0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({VGA_x, VGA_y, VGA_color} !== '0)
            begin errors++; $display("FAIL reset_port: got %h want 0", {VGA_x, VGA_y, VGA_color}); end
        Resetn = 1'b1;
        x_in = '0; y_in = '0; color_in = '0;
        tick;
    endtask

    task automatic test_single;
        req = 3'b001;
        tick;
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant: got %b want 001", grant); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        put_pixel(0, 10'd10, 9'd20, 9'h1C0, 1'b1);
        exp_q.push_back({10'd10, 9'd20, 9'h1C0});
        tick;
        checks++; if (VGA_x !== 10'd10 || VGA_y !== 9'd20 || VGA_color !== 9'h1C0 || VGA_write !== 1'b1)
            begin errors++; $display("FAIL single_pixel: got %0d,%0d,%h,%b want 10,20,1c0,1", VGA_x, VGA_y, VGA_color, VGA_write); end
        write_in = '0;
        done = 3'b001;
        tick;
        checks++; if (grant !== '0 || busy !== 1'b1)
            begin errors++; $display("FAIL single_release: got grant=%b busy=%b want 000 1", grant, busy); end
        done = '0;
        req  = '0;
        tick;
        checks++; if (busy !== 1'b0 || grant !== '0 || VGA_write !== 1'b0)
            begin errors++; $display("FAIL single_idle: got busy=%b grant=%b write=%b want 0 000 0", busy, grant, VGA_write); end
        tick;
    endtask

    task automatic test_contention;
        logic [N-1:0] order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        int           idx   [4] = '{0, 1, 2, 0};
        int           gap;
        apply_reset;
        req = 3'b111;
        wait_grant(gap);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (grant !== order[k]) begin
                errors++;
                $display("FAIL contention_order%0d: got %b want %b", k, grant, order[k]);
            end
            burst(idx[k], 5, 1'b1, 1'b0);
            if (k < 3) begin
                wait_grant(gap);
                checks++;
                if (gap != 2) begin
                    errors++;
                    $display("FAIL contention_gap%0d: got %0d want 2", k, gap);
                end
            end
        end
        req = '0;
        repeat (3) tick;
    endtask

    task automatic test_isolation;
        int gap;
        apply_reset;
        req = 3'b011;
        wait_grant(gap);
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL isolation_grant: got %b want 001", grant); end
        burst(0, 6, 1'b1, 1'b1);
        req = '0;
        repeat (3) tick;
        checks++; if (grant !== '0) begin errors++; $display("FAIL isolation_idle: got %b want 000", grant); end
    endtask

    task automatic test_done_and_new_req;
        int gap;
        apply_reset;
        req = 3'b001;
        wait_grant(gap);
        burst(0, 1, 1'b0, 1'b0);
        put_pixel(0, 10'h155, 9'h0AA, 9'h123, 1'b1);
        exp_q.push_back({10'h155, 9'h0AA, 9'h123});
        done = 3'b001;
        req  = 3'b101;
        tick;
        checks++; if (grant !== '0 || VGA_write !== 1'b1)
            begin errors++; $display("FAIL handoff_done_cycle: got grant=%b write=%b want 000 1", grant, VGA_write); end
        write_in = '0; done = '0; req = 3'b100;
        tick;
        checks++; if (grant !== '0 || VGA_write !== 1'b0)
            begin errors++; $display("FAIL handoff_release: got grant=%b write=%b want 000 0", grant, VGA_write); end
        tick;
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL handoff_grant: got %b want 100", grant); end
        burst(2, 1, 1'b1, 1'b0);
        req = '0;
        repeat (2) tick;
    endtask

    task automatic test_reset_mid_burst;
        int gap;
        apply_reset;
        req = 3'b001;
        wait_grant(gap);
        burst(0, 30, 1'b0, 1'b0);
        put_pixel(0, 10'h3FF, 9'h1FF, 9'h1FF, 1'b1);
        Resetn = 1'b0;
        req = '0;
        tick;
        checks++; if (grant !== '0 || VGA_write !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL midreset: got grant=%b write=%b busy=%b want 000 0 0", grant, VGA_write, busy); end
        checks++; if (VGA_x !== '0) begin errors++; $display("FAIL midreset_x: got %h want 0", VGA_x); end
        Resetn = 1'b1;
        write_in = '0;
        repeat (2) tick;
        checks++; if (grant !== '0 || VGA_write !== 1'b0)
            begin errors++; $display("FAIL midreset_after: got grant=%b write=%b want 000 0", grant, VGA_write); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        int gap;
        int n;
        apply_reset;
        req = 3'b011;
        wait_grant(gap);
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL timeout_first: got %b want 001", grant); end
        n = 0;
        while (grant === 3'b001 && n < 100) begin
            tick;
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL timeout_len: got %0d want 16", n); end
        wait_grant(gap);
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL timeout_next: got %b want 010", grant); end
        burst(1, 1, 1'b1, 1'b0);
        req = 3'b001;
        repeat (5) tick;
        checks++; if (grant !== '0) begin errors++; $display("FAIL timeout_lockout: got %b want 000", grant); end
        req = '0;
        tick;
        req = 3'b001;
        wait_grant(gap);
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL timeout_regrant: got %b want 001", grant); end
        done = 3'b001;
        tick;
        done = '0;
        req  = '0;
        repeat (2) tick;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_isolation;
        test_done_and_new_req;
        test_reset_mid_burst;
`ifdef ARB_TIMEOUT_EN
        test_timeout;
`endif
        repeat (2) tick;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
